// File: rtl/piso_tx_if.sv
// Handshake and serial-line bundle for piso_tx.
// The master drives the parallel word and the abort; the slave is the transmitter.
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic             clr_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             sdata_o;
    logic             sframe_o;
    logic             done_o;

    modport master (
        output clr_i, data_i, valid_i,
        input  ready_o, sdata_o, sframe_o, done_o
    );

    modport slave (
        input  clr_i, data_i, valid_i,
        output ready_o, sdata_o, sframe_o, done_o
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, LSB first, with a frame strobe and a done pulse.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    piso_tx_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef PISO_PARITY_EN
        PAR   = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [CW-1:0]    cnt_reg;
    logic             sdata_reg;
    logic             sframe_reg;
    logic             done_reg;
`ifdef PISO_PARITY_EN
    logic             parity_reg;
`endif

    // sdata_reg always mirrors shreg_reg[0] while shifting, so it is loaded one bit ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            shreg_reg  <= '0;
            cnt_reg    <= '0;
            sdata_reg  <= 1'b0;
            sframe_reg <= 1'b0;
            done_reg   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else if (bus.clr_i) begin
            state_reg  <= IDLE;
            shreg_reg  <= '0;
            cnt_reg    <= '0;
            sdata_reg  <= 1'b0;
            sframe_reg <= 1'b0;
            done_reg   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.valid_i) begin
                        shreg_reg  <= bus.data_i;
                        cnt_reg    <= '0;
                        sdata_reg  <= bus.data_i[0];
                        sframe_reg <= 1'b1;
`ifdef PISO_PARITY_EN
                        parity_reg <= ^bus.data_i;
`endif
                        state_reg  <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_reg <= shreg_reg >> 1;
                    if (cnt_reg == LAST) begin
`ifdef PISO_PARITY_EN
                        sdata_reg  <= parity_reg;
                        sframe_reg <= 1'b1;
                        state_reg  <= PAR;
`else
                        sdata_reg  <= 1'b0;
                        sframe_reg <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
`endif
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                        sdata_reg <= shreg_reg[1];
                    end
                end
`ifdef PISO_PARITY_EN
                PAR: begin
                    sdata_reg  <= 1'b0;
                    sframe_reg <= 1'b0;
                    done_reg   <= 1'b1;
                    state_reg  <= DONE;
                end
`endif
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    sdata_reg  <= 1'b0;
                    sframe_reg <= 1'b0;
                    done_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o  = (state_reg == IDLE);
    assign bus.sdata_o  = sdata_reg;
    assign bus.sframe_o = sframe_reg;
    assign bus.done_o   = done_reg;
endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter that accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, LSB first, with a frame strobe. It is the transmit end of the single-bit flop-sampled serial link used across the design. The receiving side samples `sdata_o` on each rising `clk` while `sframe_o` is high. An optional even-parity bit is appended after the data bits.

## Interface
- `WIDTH`, default 8: data word width, legal range 2..32.
- `clk`  input  1  rising-edge clock, single clock domain.
- `rst_n`  input  1  asynchronous, active-low reset.
- `clr_i`  input  1  synchronous abort; returns the block to IDLE.
- `data_i`  input  WIDTH  word to transmit; sampled on handshake.
- `valid_i`  input  1  `data_i` is valid.
- `ready_o`  output  1  block can accept a word; high only in IDLE.
- `sdata_o`  output  1  serial data bit, registered.
- `sframe_o`  output  1  high while `sdata_o` carries a data or parity bit, registered.
- `done_o`  output  1  single-cycle pulse after the last bit of a frame, registered.

## Operation
- States:
  - IDLE: `ready_o`=1; handshake → SHIFT.
  - SHIFT: bits go out on `sdata_o`; after the last data bit → PAR if parity is enabled, otherwise → DONE.
  - PAR: parity bit out → DONE.
  - DONE: one cycle, then → IDLE.
- Handshake: `valid_i` && `ready_o` at a rising edge. At that edge the block loads `data_i` into the shift register, clears the bit counter, and enters SHIFT.
- SHIFT:
  - `sdata_o` = shreg[0] and `sframe_o`=1.
  - At each edge: shreg shifts right with zero fill and the counter increments.
  - The last data bit is transmitted while counter = WIDTH-1.
- Bit counter: width $clog2(WIDTH); it never wraps inside a frame.
- DONE: `sframe_o`=0, `sdata_o`=0, `done_o`=1, `ready_o`=0.
- `valid_i` is ignored outside IDLE. `data_i` may change freely after the handshake.
- `clr_i`:
  - Has priority over everything, including a handshake in the same cycle.
  - At the next edge: state → IDLE, `sframe_o`=0, `sdata_o`=0, `done_o`=0, and the shift register and counter are cleared.
  - No `done_o` is produced for an aborted frame.
- Reset (`rst_n`=0, asynchronous): state=IDLE, `ready_o`=1, `sdata_o`=0, `sframe_o`=0, `done_o`=0, and the shift register, counter and parity are cleared. Reset mid-frame drops the frame silently.
- Idle line level: `sdata_o`=0 whenever `sframe_o`=0.

## Timing
- Handshake at edge k:
  - Data bit i is presented in cycle k+1+i, for i = 0..WIDTH-1.
  - The parity bit (if enabled) is presented in cycle k+1+WIDTH.
  - `done_o` is high in the cycle after the last bit.
  - `ready_o` rises in the cycle after `done_o`.
- Frame period without parity: WIDTH+2 cycles from handshake edge to next possible handshake edge. With parity: WIDTH+3 cycles.
- Output timing: all outputs come straight from flops or from the state register; there is no combinational path from inputs to outputs.
- `ready_o` is a decode of the state register only.
- Throughput: `valid_i` held high gives back-to-back frames separated by exactly one DONE cycle plus the IDLE handshake cycle.

## Configuration
- `PISO_PARITY_EN` defined:
  - PAR state is present.
  - The parity bit is the XOR of all WIDTH bits captured at the handshake (even parity).
  - It is sent with `sframe_o`=1 in the cycle after the last data bit.
- `PISO_PARITY_EN` undefined: PAR state, parity register and parity logic are absent, and SHIFT goes directly to DONE.

## Test plan
- Reset: assert `rst_n`=0 mid-frame with WIDTH=8 → outputs immediately `ready_o`=1, `sdata_o`=0, `sframe_o`=0, `done_o`=0. After release, the next handshake transmits normally.
- Single frame, WIDTH=8, `data_i`=8'hA5, no parity:
  - `sdata_o` = 1,0,1,0,0,1,0,1 in cycles k+1..k+8 with `sframe_o`=1.
  - `done_o`=1 at k+9 and `ready_o`=1 at k+10.
- Parity build, `data_i`=8'h07: data bits 1,1,1,0,0,0,0,0, then parity bit 1 at k+9 with `sframe_o`=1, and `done_o` at k+10. Repeat with `data_i`=8'h03 → parity bit 0.
- Back-to-back: `valid_i` held high with words 8'h01 then 8'h80 → second frame starts exactly WIDTH+2 cycles after the first handshake. No extra bits and no missed words.
- Abort: `clr_i`=1 for one cycle during bit 3 → next cycle `sframe_o`=0 and `ready_o`=1, and no `done_o` pulse. A `valid_i` arriving in the same cycle as `clr_i` is not accepted.
- Ignored input: toggle `valid_i` and `data_i` during SHIFT → transmitted bits match the word captured at the handshake only.
